// File: rtl/fpu_pkg.sv
// Shared constants for the FPU writeback stage: FCSR field layout, flag indices
// and the trap FSM state type.
package fpu_pkg;
   localparam int NUM_FLAGS = 5;

   localparam int FCSR_RM_LSB    = 0;
   localparam int FCSR_FLAG_LSB  = 2;
   localparam int FCSR_EN_LSB    = 7;
   localparam int FCSR_CAUSE_LSB = 12;
   localparam int FCSR_USED_W    = FCSR_CAUSE_LSB + NUM_FLAGS;

   localparam int FLAG_I = 0;
   localparam int FLAG_U = 1;
   localparam int FLAG_O = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_V = 4;

   typedef enum logic {
      RUN = 1'b0,
      EXC = 1'b1
   } wb_state_e;
endpackage

// File: rtl/fpu_writeback_if.sv
// Result handshake from an FPU arithmetic unit into the writeback stage.
interface fpu_writeback_if
   import fpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_result;
   logic [ADDR_W-1:0]    in_dest;
   logic [NUM_FLAGS-1:0] in_flags;

   modport master (
      output in_valid, in_result, in_dest, in_flags,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_result, in_dest, in_flags,
      output in_ready
   );
endinterface

// File: rtl/fpu_wb_fifo.sv
// Two-entry synchronous FIFO; slot0 is always the head, so pops shift slot1 down.
module fpu_wb_fifo #(
   parameter int ENTRY_W = 42
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               flush_i,
   input  logic [ENTRY_W-1:0] din_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic [1:0]         count_o
);
   logic [ENTRY_W-1:0] slot0_q, slot1_q;
   logic [1:0]         count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // Push is never offered when full, so push+pop only occurs at count 1.
   always_ff @(posedge clk) begin
      if (push_i && (count_q == 2'd0 || (pop_i && count_q == 2'd1))) begin
         slot0_q <= din_i;
      end else if (pop_i) begin
         slot0_q <= slot1_q;
      end
      if (push_i && !pop_i && count_q == 2'd1) begin
         slot1_q <= din_i;
      end
   end

   assign head_o  = slot0_q;
   assign count_o = count_q;
endmodule

// File: rtl/fpu_writeback.sv
// FPU writeback stage: buffers results, writes the FP register file, keeps the
// FCSR and raises a trap instead of writing when an enabled exception is seen.
module fpu_writeback
   import fpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fpu_writeback_if.slave       in_if,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [DATA_W-1:0]    wr_data,
   input  logic                 fcsr_we,
   input  logic [31:0]          fcsr_wdata,
   output logic [31:0]          fcsr_rdata,
   output logic [1:0]           rm,
   output logic                 exc_req,
   output logic [NUM_FLAGS-1:0] exc_cause,
   input  logic                 exc_ack
);
   localparam int ENTRY_W = DATA_W + ADDR_W + NUM_FLAGS;

   wb_state_e            state_q, state_d;
   logic [1:0]           rm_q, rm_d;
   logic [NUM_FLAGS-1:0] flag_q, flag_d, en_q, en_d, cause_q, cause_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]    wr_data_q, wr_data_d;
   logic                 exc_req_q, exc_req_d;
   logic [NUM_FLAGS-1:0] exc_cause_q, exc_cause_d;

   logic                 push, pop, flush;
   logic [1:0]           count;
   logic [ENTRY_W-1:0]   head;
   logic [DATA_W-1:0]    head_result;
   logic [ADDR_W-1:0]    head_dest;
   logic [NUM_FLAGS-1:0] head_flags, trap;
   logic                 fcsr_unused;

   assign in_if.in_ready = (count != 2'd2);
   assign push           = in_if.in_valid && in_if.in_ready;

   fpu_wb_fifo #(.ENTRY_W(ENTRY_W)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   ({in_if.in_result, in_if.in_dest, in_if.in_flags}),
      .head_o  (head),
      .count_o (count)
   );

   assign {head_result, head_dest, head_flags} = head;
   assign trap = head_flags & en_q;

   always_comb begin
      state_d     = state_q;
      rm_d        = rm_q;
      flag_d      = flag_q;
      en_d        = en_q;
      cause_d     = cause_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      exc_req_d   = exc_req_q;
      exc_cause_d = exc_cause_q;
      pop         = 1'b0;
      flush       = 1'b0;

      // A CTC1 write owns the cycle; the head simply waits one more cycle.
      if (fcsr_we) begin
         rm_d    = fcsr_wdata[FCSR_RM_LSB +: 2];
         flag_d  = fcsr_wdata[FCSR_FLAG_LSB +: NUM_FLAGS];
         en_d    = fcsr_wdata[FCSR_EN_LSB +: NUM_FLAGS];
         cause_d = fcsr_wdata[FCSR_CAUSE_LSB +: NUM_FLAGS];
      end else if (state_q == RUN && count != 2'd0) begin
         cause_d = head_flags;
         if (trap == '0) begin
            pop       = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = head_dest;
            wr_data_d = head_result;
            flag_d    = flag_q | head_flags;
         end else begin
            exc_req_d   = 1'b1;
            exc_cause_d = trap;
            state_d     = EXC;
         end
      end

      if (state_q == EXC && exc_ack) begin
         flush       = 1'b1;
         exc_req_d   = 1'b0;
         exc_cause_d = '0;
         state_d     = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         rm_q        <= '0;
         flag_q      <= '0;
         en_q        <= '0;
         cause_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         exc_req_q   <= 1'b0;
         exc_cause_q <= '0;
      end else begin
         state_q     <= state_d;
         rm_q        <= rm_d;
         flag_q      <= flag_d;
         en_q        <= en_d;
         cause_q     <= cause_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         exc_req_q   <= exc_req_d;
         exc_cause_q <= exc_cause_d;
      end
   end

   assign fcsr_unused = ^fcsr_wdata[31:FCSR_USED_W];
   assign fcsr_rdata  = {{(32-FCSR_USED_W){1'b0}}, cause_q, en_q, flag_q, rm_q};
   assign rm          = rm_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign exc_req     = exc_req_q;
   assign exc_cause   = exc_cause_q;
endmodule

// File: tb/tb_fpu_writeback.sv
// Bench for fpu_writeback: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the writeback stage.
module tb_fpu_writeback;
   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        fcsr_we;
   logic [31:0] fcsr_wdata;
   logic [31:0] fcsr_rdata;
   logic [1:0]  rm;
   logic        exc_req;
   logic [4:0]  exc_cause;
   logic        exc_ack;

   fpu_writeback_if bus ();

   fpu_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (bus),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fcsr_we    (fcsr_we),
      .fcsr_wdata (fcsr_wdata),
      .fcsr_rdata (fcsr_rdata),
      .rm         (rm),
      .exc_req    (exc_req),
      .exc_cause  (exc_cause),
      .exc_ack    (exc_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dst;
      logic [4:0]  fl;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_fcsr;
   bit          m_trap;
   logic [4:0]  m_ecause;
   bit          m_wr_en;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   int n_cmp = 0;
   int n_err = 0;
   int n_wr  = 0;
   logic [4:0]  last_addr;
   logic [31:0] last_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: FCSR kept as one 32-bit word, buffer as a queue of results.
   task automatic model_edge();
      bit         acc, flush;
      ent_t       h;
      logic [4:0] t;
      if (!rst_n) begin
         mq.delete();
         m_fcsr = 0; m_trap = 0; m_ecause = 0;
         m_wr_en = 0; m_waddr = 0; m_wdata = 0;
         return;
      end
      acc     = bus.in_valid && (mq.size() < 2);
      flush   = m_trap && exc_ack;
      m_wr_en = 0;
      if (fcsr_we) begin
         m_fcsr = fcsr_wdata & 32'h0001_FFFF;
      end else if (!m_trap && mq.size() > 0) begin
         h = mq[0];
         t = h.fl & m_fcsr[11:7];
         m_fcsr[16:12] = h.fl;
         if (t == 0) begin
            m_fcsr[6:2] = m_fcsr[6:2] | h.fl;
            m_wr_en = 1; m_waddr = h.dst; m_wdata = h.res;
            void'(mq.pop_front());
         end else begin
            m_trap = 1; m_ecause = t;
         end
      end
      if (acc) mq.push_back('{res: bus.in_result, dst: bus.in_dest, fl: bus.in_flags});
      if (flush) begin
         mq.delete(); m_trap = 0; m_ecause = 0;
      end
   endtask

   task automatic compare_all();
      chk("in_ready",   bus.in_ready, (mq.size() < 2));
      chk("wr_en",      wr_en,        m_wr_en);
      chk("wr_addr",    wr_addr,      m_waddr);
      chk("wr_data",    wr_data,      m_wdata);
      chk("exc_req",    exc_req,      m_trap);
      chk("exc_cause",  exc_cause,    m_ecause);
      chk("fcsr_rdata", fcsr_rdata,   m_fcsr);
      chk("rm",         rm,           m_fcsr[1:0]);
      if (wr_en === 1'b1) begin
         n_wr++; last_addr = wr_addr; last_data = wr_data;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      bus.in_valid = 0; fcsr_we = 0; exc_ack = 0;
   endtask

   task automatic push(input logic [31:0] res, input logic [4:0] dst, input logic [4:0] fl);
      bus.in_valid = 1; bus.in_result = res; bus.in_dest = dst; bus.in_flags = fl;
   endtask

   task automatic ctc1(input logic [31:0] d);
      idle(); fcsr_we = 1; fcsr_wdata = d; step(); idle();
   endtask

   initial begin
      rst_n = 0; idle(); fcsr_wdata = 0;
      bus.in_result = 0; bus.in_dest = 0; bus.in_flags = 0;
      step(); step();
      chk("rst_ready", bus.in_ready, 1);
      rst_n = 1;

      // Single clean result
      n_wr = 0;
      push(32'h3FC0_0000, 5'd3, 5'h00); step();
      idle(); step(); step(); step();
      chk("t1_wr_cnt", n_wr, 1);
      chk("t1_addr", last_addr, 3);
      chk("t1_data", last_data, 32'h3FC0_0000);
      chk("t1_fcsr", fcsr_rdata, 32'h0);

      // Inexact with enables off, then clean
      push(32'h1111_0000, 5'd4, 5'h01); step();
      idle(); step(); step();
      chk("t2_fcsr_i", fcsr_rdata, 32'h0000_1004);
      push(32'h2222_0000, 5'd6, 5'h00); step();
      idle(); step(); step();
      chk("t2_fcsr_clr", fcsr_rdata, 32'h0000_0004);

      // Back-to-back stream
      n_wr = 0;
      for (int i = 1; i <= 3; i++) begin
         push(32'hA000_0000 + i, 5'(i), 5'h00); step();
         chk("t3_ready", bus.in_ready, 1);
      end
      idle(); step(); step();
      chk("t3_wr_cnt", n_wr, 3);
      chk("t3_last", last_addr, 3);

      // Enabled overflow traps
      n_wr = 0;
      ctc1(32'h0000_0200);
      push(32'h7F80_0000, 5'd5, 5'h04); step();
      idle(); step(); step();
      chk("t4_req", exc_req, 1);
      chk("t4_cause", exc_cause, 5'h04);
      chk("t4_fcsr", fcsr_rdata, 32'h0000_4200);
      push(32'h0BAD_0000, 5'd9, 5'h00); step();
      chk("t4_accepted_full", bus.in_ready, 0);
      idle(); exc_ack = 1; step(); idle();
      chk("t4_ack_req", exc_req, 0);
      chk("t4_ack_ready", bus.in_ready, 1);
      step(); step();
      chk("t4_no_wr", n_wr, 0);

      // CTC1 collides with a draining underflow
      ctc1(32'h0);
      push(32'h0000_0001, 5'd7, 5'h02); step();
      idle(); fcsr_we = 1; fcsr_wdata = 32'h0000_0001; step(); idle();
      chk("t5_stalled", wr_en, 0);
      step();
      chk("t5_wr_late", wr_en, 1);
      step();
      chk("t5_fcsr", fcsr_rdata, 32'h0000_2009);

      // Fill while trapped, then reset
      ctc1(32'h0000_0F80);
      for (int i = 0; i < 3; i++) begin
         push(32'hC000_0000 + i, 5'(10 + i), 5'h10); step();
      end
      chk("t6_full", bus.in_ready, 0);
      chk("t6_req", exc_req, 1);
      idle(); rst_n = 0; step(); rst_n = 1;
      chk("t6_ready", bus.in_ready, 1);
      chk("t6_wr_en", wr_en, 0);
      chk("t6_fcsr", fcsr_rdata, 0);
      chk("t6_req0", exc_req, 0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         rst_n          = ($urandom_range(0, 299) != 0);
         bus.in_valid   = ($urandom_range(0, 2) != 0);
         bus.in_result  = $urandom;
         bus.in_dest    = 5'($urandom);
         bus.in_flags   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
         fcsr_we        = ($urandom_range(0, 11) == 0);
         fcsr_wdata     = $urandom;
         exc_ack        = ($urandom_range(0, 3) == 0);
         step();
      end
      idle(); rst_n = 1; step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fpu_writeback.md
# fpu_writeback

Downstream stage of the floating-point divider (and any other FPU arithmetic unit) in the MIPS datapath. It accepts each FP result, destination register and IEEE exception flags over a valid/ready handshake. It buffers up to two results and writes them to the FP register file. It also maintains the FCSR: rounding mode, enables, sticky flags and cause. When an enabled exception occurs, it traps instead of writing the result.

## Interface
- `DATA_W`, default 32: result width.
- `ADDR_W`, default 5: FP register address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream result present.
- `in_ready` out 1: stage can accept.
- `in_result` in DATA_W: FP result word.
- `in_dest` in ADDR_W: destination FP register.
- `in_flags` in 5: exception flags {V,Z,O,U,I} (invalid, divzero, overflow, underflow, inexact).
- `wr_en` out 1: FP register file write strobe.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out DATA_W: write data.
- `fcsr_we` in 1: CTC1 write to FCSR.
- `fcsr_wdata` in 32: CTC1 data.
- `fcsr_rdata` out 32: current FCSR (CFC1), combinational from register.
- `rm` out 2: rounding mode, FCSR[1:0].
- `exc_req` out 1: FP exception trap request, level.
- `exc_cause` out 5: enabled-and-raised flags of the trapping entry.
- `exc_ack` in 1: trap taken; flush.

## Operation
- FCSR layout (all other bits read 0):
  - [1:0] RM.
  - [6:2] sticky flags I,U,O,Z,V.
  - [11:7] enables I,U,O,Z,V.
  - [16:12] cause I,U,O,Z,V.
- `in_flags` bit i maps to flag/enable/cause bit i of each field (I=0 … V=4).
- 2-entry FIFO of {result, dest, flags}.
  - Push on `in_valid && in_ready`.
  - `in_ready = (count != 2)`; no same-cycle bypass when full.
- FSM states: RUN, EXC.
- In RUN, head valid, `fcsr_we=0` → evaluate `t = head.flags & enables`:
  - `t==0`: pop. `wr_*` load head and `wr_en=1` for one cycle. Cause ← head.flags. Sticky flags |= head.flags.
  - `t!=0`: no pop, `wr_en=0`. Cause ← head.flags. Sticky flags unchanged. `exc_cause` ← t, `exc_req` ← 1, → EXC.
- `fcsr_we=1`: FCSR ← `fcsr_wdata` masked to [16:0]. No pop or evaluation that cycle; head waits.
- In EXC:
  - No pops. Pushes are still accepted until full.
  - `exc_req` holds until `exc_ack`.
  - `exc_ack` (EXC only; ignored in RUN) → FIFO flushed (count←0, including any same-cycle push), `exc_req`←0, `exc_cause`←0, → RUN.
- `fcsr_we` with `exc_ack` in the same cycle: both take effect.
- Reset (any state, any count): count←0, RUN, FCSR←0, `wr_en`/`wr_addr`/`wr_data`/`exc_req`/`exc_cause`←0, so `in_ready`=1.

## Timing
- Push at edge k → head evaluated in cycle k..k+1 → `wr_en` high in the cycle after edge k+1 (2-edge latency).
- FCSR update is visible on `fcsr_rdata` after edge k+1.
- Sustained throughput is 1 result/cycle; count never exceeds 1 with no stalls.
- `wr_*`, `exc_req` and `exc_cause` are registered outputs.
- `in_ready` is derived from registered count only.
- `fcsr_we` stalls drain exactly one cycle per asserted cycle.

## Structure
- Package `fpu_pkg`:
  - FCSR field offsets (RM, FLAG, EN, CAUSE).
  - Flag index constants (I,U,O,Z,V).
  - `NUM_FLAGS=5`.
  - FSM state enum {RUN, EXC}.
- Sub-module `fpu_wb_fifo`: 2-entry synchronous FIFO with push, pop, flush, count and head outputs.
- Top level contains the FSM, FCSR register and write-port registers.

## Test plan
- Reset, push 0x3FC00000, dest 3, flags 0 → one `wr_en` pulse, `wr_addr`=3, `wr_data`=0x3FC00000, `fcsr_rdata`=0.
- Enables 0, push flags I (0x01) → written; `fcsr_rdata`=0x00001004. Then push flags 0 → cause cleared, `fcsr_rdata`=0x00000004.
- Hold `in_valid` for 3 results (dest 1,2,3) → `in_ready` stays 1, three consecutive `wr_en` cycles in order.
- CTC1 0x00000200 (enable O), push flags O (0x04) dest 5 → no `wr_en`, `exc_req`=1, `exc_cause`=0x04, `fcsr_rdata`=0x00004200. Push a second result while waiting → accepted. `exc_ack` → `exc_req`=0, count 0, no writes ever occur.
- `fcsr_we` (wdata 0x00000001) in the cycle a flags-U result would drain → write delayed one cycle, final `fcsr_rdata`=0x00002009.
- Fill FIFO (count 2, `in_ready`=0), assert `rst_n`=0 one cycle → next edge count 0, `in_ready`=1, `wr_en`=0, `fcsr_rdata`=0, `exc_req`=0.
